// File: rtl/jt12_lfo_pkg.sv
// Shared sizes and helpers for the jt12 LFO.
// Holds the period table and the AM triangle fold.
package jt12_lfo_pkg;

    localparam int PHASE_W = 7;
    localparam int DIV_W   = 7;

    // Samples per phase step minus one, indexed by the LFO frequency register
    function automatic logic [DIV_W-1:0] lfo_terminal(input logic [2:0] freq);
        logic [DIV_W-1:0] t;
        case (freq)
            3'd0:    t = 7'd107;
            3'd1:    t = 7'd76;
            3'd2:    t = 7'd70;
            3'd3:    t = 7'd66;
            3'd4:    t = 7'd61;
            3'd5:    t = 7'd43;
            3'd6:    t = 7'd7;
            default: t = 7'd4;
        endcase
        return t;
    endfunction

    function automatic logic [PHASE_W-2:0] lfo_am_fold(input logic [PHASE_W-1:0] phase);
        logic [PHASE_W-2:0] am;
        am = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
        return am;
    endfunction

endpackage

// File: rtl/jt12_lfo_div.sv
// LFO prescaler: counts sample ticks and pulses step on the tick that reaches the terminal count.
module jt12_lfo_div
    import jt12_lfo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [DIV_W-1:0] terminal,
    output logic             step
);

    logic [DIV_W-1:0] div;

    // >= so that lowering the terminal mid-count steps at once instead of wrapping through 127
    assign step = tick & (div >= terminal);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div <= '0;
        end else if (step) begin
            div <= '0;
        end else if (tick) begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/jt12_lfo_gen.sv
// jt12 low-frequency oscillator: phase counter plus PM index and AM triangle decode.
// Optional lfo_step pulse output when JT12_LFO_STEP_EN is defined.
module jt12_lfo_gen
    import jt12_lfo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               zero,
    input  logic               lfo_en,
    input  logic [2:0]         lfo_freq,
    output logic [4:0]         lfo_mod,
    output logic [PHASE_W-2:0] lfo_am,
    output logic [PHASE_W-1:0] lfo_phase
`ifdef JT12_LFO_STEP_EN
    ,
    output logic               lfo_step
`endif
);

    logic               tick;
    logic               clear;
    logic               step;
    logic [PHASE_W-1:0] phase;

    // A disabled LFO is held cleared on every chip-enabled cycle, tick or not
    assign tick  = clk_en & zero & lfo_en;
    assign clear = clk_en & ~lfo_en;

    jt12_lfo_div u_div (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clear    (clear),
        .terminal (lfo_terminal(lfo_freq)),
        .step     (step)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
        end else if (step) begin
            phase <= phase + 1'b1;
        end
    end

    assign lfo_mod   = phase[PHASE_W-1 -: 5];
    assign lfo_am    = lfo_am_fold(phase);
    assign lfo_phase = phase;

`ifdef JT12_LFO_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lfo_step <= 1'b0;
        end else begin
            lfo_step <= step;
        end
    end
`else
    // no step pulse output in the default build
`endif

endmodule

// File: tb/tb_jt12_lfo_gen.sv
// Self-checking bench for jt12_lfo_gen: directed scenarios plus random stimulus against a sample-level model.
module tb_jt12_lfo_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       zero = 1'b0;
    logic       lfo_en = 1'b0;
    logic [2:0] lfo_freq = 3'd0;
    logic [4:0] lfo_mod;
    logic [5:0] lfo_am;
    logic [6:0] lfo_phase;
`ifdef JT12_LFO_STEP_EN
    logic       lfo_step;
    int         step_count = 0;
    bit         prev_step = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    int periods[8] = '{108, 77, 71, 67, 62, 44, 8, 5};
    int m_div = 0;
    int m_phase = 0;
    bit m_step = 1'b0;
    int cur_freq = 0;

    always #5 clk = ~clk;

    jt12_lfo_gen dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .zero      (zero),
        .lfo_en    (lfo_en),
        .lfo_freq  (lfo_freq),
        .lfo_mod   (lfo_mod),
        .lfo_am    (lfo_am),
        .lfo_phase (lfo_phase)
`ifdef JT12_LFO_STEP_EN
        ,
        .lfo_step  (lfo_step)
`endif
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the phase
    task automatic checkModel();
        checkOutput("phase", int'(lfo_phase), m_phase);
        checkOutput("mod", int'(lfo_mod), m_phase / 4);
        checkOutput("am", int'(lfo_am), (m_phase >= 64) ? (127 - m_phase) : m_phase);
`ifdef JT12_LFO_STEP_EN
        checkOutput("step", int'(lfo_step), int'(m_step));
        if (lfo_step && prev_step) checkOutput("step_wide", 1, 0);
        if (lfo_step) step_count++;
        prev_step = lfo_step;
`endif
    endtask

    // One clock: drive inputs, advance the model by the sample rules, then compare
    task automatic applyStimulus(input bit ce, input bit z, input bit en, input int fr, input bit r);
        clk_en   = ce;
        zero     = z;
        lfo_en   = en;
        lfo_freq = 3'(fr);
        rst      = r;
        @(posedge clk);
        #1;
        m_step = 1'b0;
        if (r) begin
            m_div = 0;
            m_phase = 0;
        end else if (ce) begin
            if (!en) begin
                m_div = 0;
                m_phase = 0;
            end else if (z) begin
                if (m_div >= periods[fr] - 1) begin
                    m_div = 0;
                    m_phase = (m_phase + 1) % 128;
                    m_step = 1'b1;
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
        checkModel();
    endtask

    task automatic runTicks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, cur_freq, 1'b0);
            for (int g = 1; g < gap; g++) applyStimulus(1'b1, 1'b0, 1'b1, cur_freq, 1'b0);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, cur_freq, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, cur_freq, 1'b1);
    endtask

    // Tick every cycle until the phase reaches target, bounded by one full lap
    task automatic runUntil(input string tag, input int target);
        int n;
        n = 0;
        while (m_phase != target && n < 14000) begin
            runTicks(1, 1);
            n++;
        end
        checkOutput(tag, int'(lfo_phase), target);
    endtask

    initial begin
        int saved;

        doReset();
        checkOutput("reset_phase", int'(lfo_phase), 0);
        checkOutput("reset_am", int'(lfo_am), 0);

        // Fastest rate, one tick every four clocks
        cur_freq = 7;
        runTicks(5, 4);
        checkOutput("f7_5ticks", int'(lfo_phase), 1);
        checkOutput("f7_5mod", int'(lfo_mod), 0);
        runTicks(15, 4);
        checkOutput("f7_20ticks", int'(lfo_phase), 4);
        checkOutput("f7_20mod", int'(lfo_mod), 1);
        runTicks(620, 4);
        checkOutput("f7_wrap", int'(lfo_phase), 0);

        // Each period: no step one tick early, step exactly on the last tick
        for (int f = 0; f < 7; f++) begin
            cur_freq = f;
            doReset();
            runTicks(periods[f] - 1, 1);
            checkOutput($sformatf("per%0d_early", f), int'(lfo_phase), 0);
            runTicks(1, 1);
            checkOutput($sformatf("per%0d_step", f), int'(lfo_phase), 1);
        end

        // Lowering the period below the current count steps on the next tick
        cur_freq = 0;
        doReset();
        runTicks(100, 1);
        cur_freq = 6;
        runTicks(1, 1);
        checkOutput("shrink_step", int'(lfo_phase), 1);
        runTicks(7, 1);
        checkOutput("shrink_hold", int'(lfo_phase), 1);
        runTicks(1, 1);
        checkOutput("shrink_next", int'(lfo_phase), 2);

        // AM fold boundaries
        cur_freq = 7;
        doReset();
        runUntil("reach63", 63);
        checkOutput("am63", int'(lfo_am), 63);
        runUntil("reach64", 64);
        checkOutput("am64", int'(lfo_am), 63);
        runUntil("reach127", 127);
        checkOutput("am127", int'(lfo_am), 0);
        checkOutput("mod127", int'(lfo_mod), 31);
        runUntil("reach0", 0);
        checkOutput("am0", int'(lfo_am), 0);

        // Disable clears; re-enable waits a full period
        runUntil("reach37", 37);
        applyStimulus(1'b1, 1'b1, 1'b0, cur_freq, 1'b0);
        checkOutput("dis_phase", int'(lfo_phase), 0);
        checkOutput("dis_am", int'(lfo_am), 0);
        runTicks(4, 1);
        checkOutput("reen_early", int'(lfo_phase), 0);
        runTicks(1, 1);
        checkOutput("reen_step", int'(lfo_phase), 1);

        // Reset mid-period behaves the same
        runUntil("reach37b", 37);
        runTicks(2, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, cur_freq, 1'b1);
        checkOutput("rst_phase", int'(lfo_phase), 0);
        runTicks(4, 1);
        checkOutput("rst_early", int'(lfo_phase), 0);
        runTicks(1, 1);
        checkOutput("rst_step", int'(lfo_phase), 1);

        // Ticks without clock enable are ignored
        runTicks(12, 1);
        saved = m_phase;
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b1, cur_freq, 1'b0);
        checkOutput("ce_hold", int'(lfo_phase), saved);

`ifdef JT12_LFO_STEP_EN
        doReset();
        step_count = 0;
        runTicks(640, 2);
        checkOutput("step_pulses", step_count, 128);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) cur_freq = $urandom_range(0, 7);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 15) != 0, cur_freq, $urandom_range(0, 511) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
